// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
// Holds the access width codes and the responder FSM encoding.
package mem_pkg;

   typedef enum logic [2:0] {
      WIDTH_WORD = 3'd0,
      WIDTH_HALF = 3'd1,
      WIDTH_BYTE = 3'd2
   } width_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned WORD_BYTES = 4;

   function automatic logic [WORD_BYTES-1:0] half_lanes(input logic upper);
      return upper ? 4'b1100 : 4'b0011;
   endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering for one 32-bit word: store merge and load extract.
// Purely combinational; also flags illegal width codes and misalignment.
module mem_lane_unit
   import mem_pkg::*;
(
   input  logic [2:0]  width,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   output logic [31:0] new_word,
   output logic [31:0] load_data,
   output logic        bad_access
);

   logic [3:0]  be;
   logic [31:0] lane_data;
   logic [31:0] byte_shift;

   always_comb begin
      be         = '0;
      lane_data  = '0;
      load_data  = '0;
      bad_access = 1'b0;
      byte_shift = old_word >> {addr_lo, 3'b000};
      case (width)
         WIDTH_WORD: begin
            be         = 4'b1111;
            lane_data  = wdata;
            load_data  = old_word;
            bad_access = (addr_lo != 2'b00);
         end
         WIDTH_HALF: begin
            be         = half_lanes(addr_lo[1]);
            lane_data  = {2{wdata[15:0]}};
            load_data  = {16'h0000, (addr_lo[1] ? old_word[31:16] : old_word[15:0])};
            bad_access = addr_lo[0];
         end
         WIDTH_BYTE: begin
            be         = 4'b0001 << addr_lo;
            lane_data  = {4{wdata[7:0]}};
            load_data  = {24'h000000, byte_shift[7:0]};
         end
         default: begin
            bad_access = 1'b1;
         end
      endcase
   end

   // Little-endian merge: only enabled lanes take the replicated store data.
   always_comb begin
      new_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) new_word[8*i +: 8] = lane_data[8*i +: 8];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory slave: accepts one request in IDLE, waits
// WAIT_CYCLES, then answers with a one-cycle ready strobe.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 3072,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  width,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int unsigned CNT_MAX = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

   state_e           state;
   logic [CNT_W-1:0] cnt;

   logic        we_p0;
   logic [2:0]  width_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;

   logic [31:0] mem [DEPTH_WORDS];

   logic             in_idle;
   logic             going_resp;
   logic             cur_we;
   logic [2:0]       cur_width;
   logic [31:0]      cur_addr;
   logic [31:0]      cur_wdata;
   logic [IDX_W-1:0] cur_idx;
   logic             out_of_range;
   logic             lane_bad;
   logic             cur_err;
   logic             commit;
   logic [31:0]      old_word;
   logic [31:0]      new_word;
   logic [31:0]      load_data;

   // With no wait states the response is formed straight from the live
   // inputs on the accepting edge; otherwise from the captured request.
   assign in_idle   = (state == IDLE);
   assign cur_we    = in_idle ? we    : we_p0;
   assign cur_width = in_idle ? width : width_p0;
   assign cur_addr  = in_idle ? addr  : addr_p0;
   assign cur_wdata = in_idle ? wdata : wdata_p0;
   assign cur_idx   = cur_addr[IDX_W+1:2];

   assign going_resp = reset &&
                       ((in_idle && req && NO_WAIT) ||
                        ((state == WAIT) && (cnt == CNT_W'(CNT_MAX))));

   assign out_of_range = ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
   assign old_word     = out_of_range ? '0 : mem[cur_idx];
   assign cur_err      = lane_bad || out_of_range;
   assign commit       = going_resp && cur_we && !cur_err;

   mem_lane_unit u_lane (
      .width      (cur_width),
      .addr_lo    (cur_addr[1:0]),
      .wdata      (cur_wdata),
      .old_word   (old_word),
      .new_word   (new_word),
      .load_data  (load_data),
      .bad_access (lane_bad)
   );

   // Stage p0: request capture, data only, held until the next accept.
   always_ff @(posedge clk) begin
      if (in_idle && req) begin
         we_p0    <= we;
         width_p0 <= width;
         addr_p0  <= addr;
         wdata_p0 <= wdata;
      end
   end

   // Storage is never reset; writes land on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (commit) mem[cur_idx] <= new_word;
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (req) state <= NO_WAIT ? RESP : WAIT;
            end
            WAIT: begin
               if (cnt == CNT_W'(CNT_MAX)) begin
                  state <= RESP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (going_resp) begin
            ready <= 1'b1;
            err   <= cur_err;
            rdata <= (cur_err || cur_we) ? '0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, abort/back-to-back sequences,
// a zero-wait build, and randomized traffic against a byte-level model.
module tb_mem_responder;

   localparam int unsigned DEPTH  = 3072;
   localparam int unsigned W      = 2;
   localparam int unsigned DEPTH0 = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we;
   logic [2:0]  width;
   logic [31:0] addr, wdata, rdata;
   logic        ready, err;
   logic        req0, we0;
   logic [2:0]  width0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ready0, err0;

   int checks = 0;
   int errors = 0;

   logic [7:0] mb [int unsigned];

   typedef struct {
      bit        we;
      bit [2:0]  width;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit        exp_err;
      bit [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [19];

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .width(width),
      .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
   );

   mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .width(width0),
      .addr(addr0), .wdata(wdata0), .ready(ready0), .rdata(rdata0), .err(err0)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit s, input bit r, input bit twe, input bit [2:0] tw,
                        input bit [31:0] ta, input bit [31:0] td);
      if (!s) begin
         req = r; we = twe; width = tw; addr = ta; wdata = td;
      end else begin
         req0 = r; we0 = twe; width0 = tw; addr0 = ta; wdata0 = td;
      end
   endtask

   task automatic do_txn(input bit s, input bit twe, input bit [2:0] tw,
                         input bit [31:0] ta, input bit [31:0] td,
                         output bit oe, output bit [31:0] od);
      int lat;
      bit got;
      int exp_lat;
      exp_lat = s ? 1 : W + 1;
      @(negedge clk);
      drive(s, 1'b1, twe, tw, ta, td);
      @(posedge clk);
      @(negedge clk);
      drive(s, 1'b0, ~twe, 3'd2, ta ^ 32'h3, ~td);
      lat = 1; got = 0; oe = 0; od = 0;
      while (!got && lat <= 12) begin
         if (s ? ready0 : ready) begin
            got = 1;
            oe  = s ? err0 : err;
            od  = s ? rdata0 : rdata;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      chk("ready_seen", got, 1);
      if (got) chk("ready_latency", lat, exp_lat);
      @(negedge clk);
      chk("ready_one_cycle", s ? ready0 : ready, 0);
      chk("rdata_zero_idle", s ? rdata0 : rdata, 0);
   endtask

   task automatic model_txn(input bit mwe, input bit [2:0] mw, input bit [31:0] ma,
                            input bit [31:0] md, output bit me, output bit [31:0] mr);
      int n;
      me = (mw > 3'd2) || (mw == 3'd1 && ma[0]) || (mw == 3'd0 && ma[1:0] != 2'b00)
           || ((ma / 4) >= DEPTH);
      mr = 0;
      if (me) return;
      n = (mw == 3'd0) ? 4 : (mw == 3'd1) ? 2 : 1;
      for (int i = 0; i < n; i++) begin
         if (mwe) mb[ma + i] = md[8*i +: 8];
         else     mr = mr | (32'(mb[ma + i]) << (8 * i));
      end
   endtask

   task automatic back_to_back();
      bit [31:0] la [3];
      bit [31:0] le [3];
      int pulses;
      int nxt;
      bit exp_rdy;
      la[0] = 32'h10;   le[0] = 32'h1234AB78;
      la[1] = 32'h14;   le[1] = 32'hCAFEF00D;
      la[2] = 32'h2FFC; le[2] = 32'h0BADF00D;
      pulses = 0; nxt = 1;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 3'd0, la[0], 32'h0);
      @(posedge clk);
      for (int j = 0; j < 3 * (W + 2) + 2; j++) begin
         @(negedge clk);
         exp_rdy = ((j % (W + 2)) == W) && (j < 3 * (W + 2));
         chk($sformatf("b2b_ready_j%0d", j), ready, exp_rdy);
         if (ready) begin
            if (pulses < 3) chk($sformatf("b2b_rdata_%0d", pulses), rdata, le[pulses]);
            pulses++;
         end
         if ((j % (W + 2)) == W + 1) begin
            if (nxt < 3) begin
               addr = la[nxt]; we = 1'b0; width = 3'd0;
               nxt++;
            end else begin
               req = 1'b0;
            end
         end else begin
            addr  = $urandom | 32'h1;
            we    = 1'b1;
            width = 3'($urandom_range(0, 2));
            wdata = $urandom;
         end
      end
      req = 1'b0;
      chk("b2b_pulse_count", pulses, 3);
   endtask

   initial begin
      bit        e, me;
      bit [31:0] d, md;
      bit        twe;
      bit [2:0]  tw;
      bit [31:0] ta, td;
      int        saw;

      tbl[0]  = '{1'b1, 3'd0, 32'h10,   32'h12345678, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 3'd0, 32'h10,   32'h0,        1'b0, 32'h12345678};
      tbl[2]  = '{1'b1, 3'd2, 32'h11,   32'hAB,       1'b0, 32'h0};
      tbl[3]  = '{1'b0, 3'd1, 32'h12,   32'h0,        1'b0, 32'h00001234};
      tbl[4]  = '{1'b0, 3'd0, 32'h10,   32'h0,        1'b0, 32'h1234AB78};
      tbl[5]  = '{1'b1, 3'd0, 32'h14,   32'hCAFEF00D, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 3'd0, 32'h13,   32'h0,        1'b1, 32'h0};
      tbl[7]  = '{1'b1, 3'd1, 32'h15,   32'hFFFF,     1'b1, 32'h0};
      tbl[8]  = '{1'b0, 3'd0, 32'h14,   32'h0,        1'b0, 32'hCAFEF00D};
      tbl[9]  = '{1'b0, 3'd0, 32'h3000, 32'h0,        1'b1, 32'h0};
      tbl[10] = '{1'b0, 3'd3, 32'h10,   32'h0,        1'b1, 32'h0};
      tbl[11] = '{1'b1, 3'd3, 32'h10,   32'hDEADBEEF, 1'b1, 32'h0};
      tbl[12] = '{1'b1, 3'd0, 32'h3000, 32'h55555555, 1'b1, 32'h0};
      tbl[13] = '{1'b0, 3'd0, 32'h10,   32'h0,        1'b0, 32'h1234AB78};
      tbl[14] = '{1'b0, 3'd2, 32'h13,   32'h0,        1'b0, 32'h00000012};
      tbl[15] = '{1'b0, 3'd1, 32'h10,   32'h0,        1'b0, 32'h0000AB78};
      tbl[16] = '{1'b1, 3'd0, 32'h2FFC, 32'h0BADF00D, 1'b0, 32'h0};
      tbl[17] = '{1'b0, 3'd0, 32'h2FFC, 32'h0,        1'b0, 32'h0BADF00D};
      tbl[18] = '{1'b0, 3'd2, 32'h2FFF, 32'h0,        1'b0, 32'h0000000B};

      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("reset_ready",  ready,  0);
      chk("reset_err",    err,    0);
      chk("reset_rdata",  rdata,  0);
      chk("reset_ready0", ready0, 0);
      chk("reset_err0",   err0,   0);
      chk("reset_rdata0", rdata0, 0);
      reset = 1'b1;

      for (int i = 0; i < 19; i++) begin
         do_txn(0, tbl[i].we, tbl[i].width, tbl[i].addr, tbl[i].wdata, e, d);
         chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
         if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
      end

      // Store aborted by reset while waiting.
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 3'd0, 32'h10, 32'hFFFFFFFF);
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      reset = 1'b0;
      #1;
      chk("abort_ready_in_reset", ready, 0);
      chk("abort_rdata_in_reset", rdata, 0);
      #2;
      reset = 1'b1;
      saw = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready) saw++;
      end
      chk("abort_no_ready", saw, 0);
      do_txn(0, 1'b0, 3'd0, 32'h10, 32'h0, e, d);
      chk("abort_err", e, 0);
      chk("abort_prior_value", d, 32'h1234AB78);

      back_to_back();

      // Zero-wait build.
      do_txn(1, 1'b1, 3'd0, 32'h4, 32'hA55A_3CC3, e, d);
      chk("w0_store_err", e, 0);
      do_txn(1, 1'b0, 3'd0, 32'h4, 32'h0, e, d);
      chk("w0_load_word", d, 32'hA55A_3CC3);
      do_txn(1, 1'b0, 3'd1, 32'h6, 32'h0, e, d);
      chk("w0_load_half", d, 32'h0000_A55A);
      do_txn(1, 1'b0, 3'd0, 32'h40, 32'h0, e, d);
      chk("w0_range_err", e, 1);
      chk("w0_range_rdata", d, 0);

      // Randomized traffic over a small window plus out-of-range probes.
      for (int i = 0; i < 16; i++) begin
         td = $urandom;
         ta = 32'h80 + 32'(4 * i);
         do_txn(0, 1'b1, 3'd0, ta, td, e, d);
         model_txn(1'b1, 3'd0, ta, td, me, md);
         chk("init_err", e, me);
      end
      for (int n = 0; n < 80; n++) begin
         int r;
         twe = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r < 4)      tw = 3'd0;
         else if (r < 7) tw = 3'd1;
         else if (r < 9) tw = 3'd2;
         else            tw = 3'(3 + $urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0) ta = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
         else                           ta = 32'h80 + 32'($urandom_range(0, 63));
         td = $urandom;
         do_txn(0, twe, tw, ta, td, e, d);
         model_txn(twe, tw, ta, td, me, md);
         chk($sformatf("rnd%0d_err", n), e, me);
         if (!twe) chk($sformatf("rnd%0d_rdata", n), d, md);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
